// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART-TX bundle for uart_tx_arbiter.
// master: the arbiter. slave: the requesters and the UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned width = 8,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*width-1:0] req_data;
  logic [NREQ-1:0]       req_par_en;
  logic [NREQ-1:0]       req_par_type;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  Data_valid;
  logic [width-1:0]      P_data;
  logic                  Par_en;
  logic                  Par_type;
  logic                  Busy;
  logic                  err;

  modport master (
    input  req, req_data, req_par_en, req_par_type, Busy,
    output gnt, done, Data_valid, P_data, Par_en, Par_type, err
  );

  modport slave (
    output req, req_data, req_par_en, req_par_type, Busy,
    input  gnt, done, Data_valid, P_data, Par_en, Par_type, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NREQ requesters.
// Optional Busy-acknowledge timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned width = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TMO   = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..8 and TMO at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             dv_q, dv_d;
  logic [width-1:0] pdata_q, pdata_d;
  logic             pen_q, pen_d;
  logic             ptype_q, ptype_d;
  logic             found_c;
  logic [IW-1:0]    pick_c;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : i + IW'(1);
  endfunction

  // First requesting index at or above ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && bus.req[IW'(idx)]) begin
        found_c = 1'b1;
        pick_c  = IW'(idx);
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    dv_d    = 1'b0;
    pdata_d = pdata_q;
    pen_d   = pen_q;
    ptype_d = ptype_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // The cycle carrying done is never an arbitration cycle.
        if (found_c && done_q == '0) begin
          win_d   = pick_c;
          gnt_d   = NREQ'(1) << pick_c;
          pdata_d = bus.req_data[32'(pick_c) * width +: width];
          pen_d   = bus.req_par_en[pick_c];
          ptype_d = bus.req_par_type[pick_c];
          dv_d    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (bus.Busy) begin
          state_d = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TMO - 1)) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = next_idx(win_q);
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      WAIT_DONE: begin
        if (!bus.Busy) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = next_idx(win_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      dv_q    <= 1'b0;
      pdata_q <= '0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      pdata_q <= pdata_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.Data_valid = dv_q;
  assign bus.P_data     = pdata_q;
  assign bus.Par_en     = pen_q;
  assign bus.Par_type   = ptype_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a UART Busy model,
// a round-robin planning model and an output monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  typedef struct {
    int unsigned idx;
    logic [7:0]  data;
    logic        pen;
    logic        ptype;
    bit          b2b;
  } frame_t;

  logic clk;
  logic rst;
  uart_tx_arbiter_if #(.width(W), .NREQ(N)) bus ();

  uart_tx_arbiter #(.width(W), .NREQ(N), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  frame_t      exp_q[$];
  logic [9:0]  rq[4][$];
  int unsigned mptr = 0;
  bit          mon_busy = 0;
  bit          hold_low = 0;
  bit          fixed_timing = 0;
  bit          glitch_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic add_word(input int unsigned i, input logic [7:0] d, input logic pe, input logic pt);
    rq[i].push_back({pt, pe, d});
  endtask

  // Plan the service order of everything just loaded: each frame goes to the
  // first non-empty requester at or after the pointer, pointer then moves past it.
  task automatic commit();
    int unsigned left[4];
    int unsigned pos[4];
    int unsigned total;
    int unsigned w;
    logic [9:0]  word;
    frame_t      f;
    bit          first;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      left[i] = rq[i].size();
      pos[i]  = 0;
      total  += left[i];
    end
    first = 1'b1;
    repeat (total) begin
      w = mptr;
      while (left[w] == 0) w = (w + 1) % N;
      word    = rq[w][pos[w]];
      f.idx   = w;
      f.data  = word[7:0];
      f.pen   = word[8];
      f.ptype = word[9];
      f.b2b   = !first;
      exp_q.push_back(f);
      first   = 1'b0;
      left[w]--;
      pos[w]++;
      mptr = (w + 1) % N;
    end
  endtask

  task automatic drive_req();
    logic [9:0] word;
    for (int i = 0; i < 4; i++) begin
      bus.req[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) begin
        word = rq[i][0];
        bus.req_data[i*8 +: 8] = word[7:0];
        bus.req_par_en[i]      = word[8];
        bus.req_par_type[i]    = word[9];
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || bus.gnt != '0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Requesters: level request while words are queued; pop on completion.
  initial begin : requesters
    int unsigned last_w;
    bit          glitched;
    last_w = 0;
    glitched = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_par_en = '0;
    bus.req_par_type = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        glitched = 1'b0;
        drive_req();
      end else begin
        for (int i = 0; i < 4; i++) if (bus.gnt[i]) last_w = i;
        for (int i = 0; i < 4; i++) if (bus.done[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (bus.err && rq[last_w].size() != 0) void'(rq[last_w].pop_front());
        if (bus.done != '0 || bus.err) glitched = 1'b0;
        if (bus.gnt != '0 && !glitched && glitch_en && $urandom_range(0, 3) == 0) begin
          glitched = 1'b1;
          bus.req[last_w] = 1'b0;
          bus.req_data[last_w*8 +: 8] = 8'($urandom);
        end else if (!glitched) begin
          drive_req();
        end
      end
    end
  end

  // UART transmitter: Busy rises d1 cycles after the strobe, falls at d2.
  initial begin : uart_model
    int unsigned t;
    int unsigned d1;
    int unsigned d2;
    bit          active;
    bus.Busy = 1'b0;
    t = 0; d1 = 2; d2 = 11; active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || bus.err) begin
        bus.Busy = 1'b0;
        active = 1'b0;
      end else if (active) begin
        if (hold_low) t = 0;
        else begin
          t++;
          if (t == d1) bus.Busy = 1'b1;
          else if (t == d2) begin
            bus.Busy = 1'b0;
            active = 1'b0;
          end
        end
      end else if (bus.Data_valid) begin
        active = 1'b1;
        t = 0;
        if (fixed_timing) begin
          d1 = 2; d2 = 11;
        end else begin
          d1 = $urandom_range(1, 4);
          d2 = d1 + $urandom_range(1, 10);
        end
      end
    end
  end

  // Monitor: pops the planned frame on each strobe and follows it to done.
  initial begin : monitor
    frame_t cur;
    int     last_done;
    last_done = -100;
    cur = '{idx: 0, data: 8'h00, pen: 1'b0, ptype: 1'b0, b2b: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_busy = 1'b0;
      end else begin
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
`ifndef UART_TX_ARB_TIMEOUT_EN
        check("err_tied_zero", 32'(bus.err), 0);
`endif
        if (bus.Data_valid) begin
          check("dv_expected", 32'(!mon_busy && exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            mon_busy = 1'b1;
            check("dv_gnt", 32'(bus.gnt), 32'(1) << cur.idx);
            check("dv_pdata", 32'(bus.P_data), 32'(cur.data));
            check("dv_par_en", 32'(bus.Par_en), 32'(cur.pen));
            check("dv_par_type", 32'(bus.Par_type), 32'(cur.ptype));
            if (cur.b2b) check("done_to_dv_gap", 32'(cyc - last_done), 2);
          end
        end else if (mon_busy && bus.done == '0 && !bus.err) begin
          check("gnt_hold", 32'(bus.gnt), 32'(1) << cur.idx);
          check("pdata_hold", 32'(bus.P_data), 32'(cur.data));
          check("par_en_hold", 32'(bus.Par_en), 32'(cur.pen));
        end
        if (bus.done != '0) begin
          check("done_expected", 32'(mon_busy), 1);
          if (mon_busy) check("done_onehot", 32'(bus.done), 32'(1) << cur.idx);
          mon_busy = 1'b0;
          last_done = cyc;
        end
        if (bus.err) begin
          check("err_expected", 32'(mon_busy), 1);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int n;
    int t_launch;
    logic [3:0] mask;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_dv", 32'(bus.Data_valid), 0);
    check("rst_pdata", 32'(bus.P_data), 0);
    check("rst_par_en", 32'(bus.Par_en), 0);
    check("rst_par_type", 32'(bus.Par_type), 0);
    check("rst_err", 32'(bus.err), 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester 2 with fixed Busy timing; also checks one-cycle latency.
    fixed_timing = 1'b1;
    @(posedge clk); #2;
    add_word(2, 8'hA5, 1'b1, 1'b0);
    commit();
    @(negedge clk);
    check("lat_pre_dv", 32'(bus.Data_valid), 0);
    @(negedge clk);
    check("lat_dv", 32'(bus.Data_valid), 1);
    check("lat_gnt", 32'(bus.gnt), 32'h4);
    wait_idle();

    // All four requesting continuously, two words each.
    fixed_timing = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) repeat (2) add_word(i, 8'($urandom), 1'($urandom), 1'($urandom));
    commit();
    wait_idle();

    // Random request patterns with mid-frame req drop / data scribble.
    glitch_en = 1'b1;
    repeat (20) begin
      @(posedge clk); #2;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        if (mask[i]) repeat ($urandom_range(1, 3)) add_word(i, 8'($urandom), 1'($urandom), 1'($urandom));
      commit();
      wait_idle();
    end
    glitch_en = 1'b0;

    // Asynchronous reset while requester 1 is in WAIT_DONE.
    fixed_timing = 1'b1;
    @(posedge clk); #2;
    add_word(1, 8'h3C, 1'b1, 1'b1);
    commit();
    n = 0;
    while (!(bus.gnt == 4'b0010 && bus.Busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_wait_done", 32'(n < 200), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_gnt", 32'(bus.gnt), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_dv", 32'(bus.Data_valid), 0);
    check("arst_pdata", 32'(bus.P_data), 0);
    check("arst_par_en", 32'(bus.Par_en), 0);
    check("arst_par_type", 32'(bus.Par_type), 0);
    check("arst_err", 32'(bus.err), 0);
    for (int i = 0; i < 4; i++) rq[i].delete();
    exp_q.delete();
    mptr = 0;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_done", 32'(bus.done), 0);
    end
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) add_word(i, 8'($urandom), 1'($urandom), 1'($urandom));
    commit();
    wait_idle();

    // Busy never acknowledged.
    hold_low = 1'b1;
    @(posedge clk); #2;
    add_word(2, 8'h5A, 1'b0, 1'b1);
    commit();
    n = 0;
    while (!bus.Data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_dv_seen", 32'(n < 20), 1);
    t_launch = cyc;
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    while (!bus.err && n < 40) begin
      @(negedge clk);
      if (!bus.err) check("tmo_gnt_before", 32'(bus.gnt), 32'h4);
      n++;
    end
    check("tmo_err_cycle", 32'(cyc - t_launch), TMO + 1);
    check("tmo_no_done", 32'(bus.done), 0);
    @(negedge clk);
    check("tmo_err_pulse", 32'(bus.err), 0);
    check("tmo_gnt_clear", 32'(bus.gnt), 0);
`else
    repeat (40) begin
      @(negedge clk);
      check("hold_gnt", 32'(bus.gnt), 32'h4);
      check("hold_done", 32'(bus.done), 0);
    end
    check("hold_elapsed", 32'(cyc - t_launch), 40);
`endif
    hold_low = 1'b0;
    wait_idle();

    // Next grant goes to the requester following 2.
    fixed_timing = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) add_word(i, 8'($urandom), 1'($urandom), 1'($urandom));
    commit();
    wait_idle();

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter width, default 8, is the data word width per frame.
REQ-002 Parameter NREQ, default 4, is the number of requesters (2..8).
REQ-003 Parameter TMO, default 16, is the Busy-acknowledge timeout in cycles; it is used only with UART_TX_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester transmit request, level.
REQ-007 req_data  in  NREQ*width  requester i word at [i*width +: width].
REQ-008 req_par_en  in  NREQ  per-requester parity enable.
REQ-009 req_par_type  in  NREQ  per-requester parity type.
REQ-010 gnt  out  NREQ  one-hot grant, registered.
REQ-011 done  out  NREQ  one-cycle frame-complete pulse to the granted requester.
REQ-012 Data_valid  out  1  one-cycle launch strobe to the UART TX.
REQ-013 P_data  out  width  word to the UART TX.
REQ-014 Par_en / Par_type  out  1 each  parity controls to the UART TX.
REQ-015 Busy  in  1  UART TX busy flag.
REQ-016 err  out  1  one-cycle timeout pulse; tied 0 when timeout is compiled out.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-018 IDLE: if any req bit is 1, the winner SHALL be the first set index searching from ptr upward, wrapping NREQ-1 to 0.
- Winner's word, par_en and par_type captured into P_data, Par_en, Par_type.
- gnt[winner] set; next state LAUNCH.
REQ-019 Latency: req sampled at edge k, so Data_valid and gnt are high in cycle k+1.
REQ-020 LAUNCH: Data_valid SHALL be 1 for exactly one cycle; next state WAIT_BUSY.
REQ-021 WAIT_BUSY: Busy=1 SHALL move to WAIT_DONE; otherwise stay.
REQ-022 WAIT_DONE: Busy=0 SHALL pulse done[winner] for one cycle, clear gnt, set ptr=(winner+1) mod NREQ, and go to IDLE.
REQ-023 P_data, Par_en and Par_type SHALL hold stable from LAUNCH until gnt clears; req_data changes during this time are ignored.
REQ-024 Deasserting req while granted SHALL NOT abort the frame; done is still issued.
REQ-025 No arbitration SHALL occur in the done cycle; the earliest next Data_valid is 2 cycles after done.
REQ-026 With all req bits 1, grants SHALL rotate 0,1,..,NREQ-1,0 with no starvation.
REQ-027 Outside LAUNCH, Data_valid SHALL be 0; gnt SHALL be one-hot or zero at all times.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, ptr=0, and gnt, done, Data_valid, P_data, Par_en, Par_type and err to 0, regardless of clock.
REQ-029 Reset mid-frame SHALL drop the frame with no done pulse; the first grant after release follows the ptr=0 priority.

Configuration
REQ-030 With UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY.
- If Busy stays 0 for TMO cycles: err pulses one cycle, gnt clears, no done, ptr advances past the winner, next state IDLE.
- The counter clears on every entry to WAIT_BUSY.
REQ-031 Without UART_TX_ARB_TIMEOUT_EN, WAIT_BUSY SHALL wait indefinitely, err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-032 Single request: req=4'b0100, data 8'hA5, par_en=1, type=0, Busy 1 two cycles after the strobe and 0 after 11 cycles -> one Data_valid pulse, P_data=8'hA5, Par_en=1, gnt=4'b0100 until done[2], then ptr=3.
REQ-033 All four requesting continuously -> grant order 0,1,2,3,0; exactly one done per frame; never two gnt bits set.
REQ-034 req[1] dropped and req_data[1] changed mid-frame -> P_data unchanged, done[1] still pulses.
REQ-035 rst pulsed low asynchronously during WAIT_DONE with gnt=4'b0010 -> all outputs 0 at once, no done; after release req=4'b1111 grants requester 0.
REQ-036 Timeout enabled, Busy held 0 -> err pulses after TMO=16 cycles in WAIT_BUSY, no done, next grant goes to the following requester; timeout disabled -> FSM stays in WAIT_BUSY and err stays 0.
